// File: rtl/trap_sequencer_if.sv
// Trap sequencer bundle: the trap-unit request and descriptor, the data-bus busy
// flag and current mstatus bits, plus the redirect/flush/CSR-commit outputs.
interface trap_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 trap_req;
    logic                 trap_is_mret;
    logic [31:0]          trap_addr;
    logic [31:0]          trap_epc;
    logic [31:0]          trap_cause;
    logic [31:0]          trap_val;
    logic                 mem_busy;
    logic                 mstatus_mie;
    logic                 mstatus_mpie;

    logic                 trap_insert;
    logic                 stall_fetch;
    logic                 flush;
    logic                 pc_load;
    logic [31:0]          pc_next;
    logic                 csr_trap_we;
    logic [31:0]          csr_mepc;
    logic [31:0]          csr_mcause;
    logic [31:0]          csr_mtval;
    logic                 csr_status_we;
    logic                 mie_next;
    logic                 mpie_next;
    logic                 drain_timeout;
    logic [CNT_WIDTH-1:0] trap_count;

    // Environment side: trap unit, execute stage and CSR file.
    modport master (
        output trap_req, trap_is_mret, trap_addr, trap_epc, trap_cause, trap_val,
        output mem_busy, mstatus_mie, mstatus_mpie,
        input  trap_insert, stall_fetch, flush, pc_load, pc_next,
        input  csr_trap_we, csr_mepc, csr_mcause, csr_mtval,
        input  csr_status_we, mie_next, mpie_next, drain_timeout, trap_count
    );

    // Sequencer side.
    modport slave (
        input  trap_req, trap_is_mret, trap_addr, trap_epc, trap_cause, trap_val,
        input  mem_busy, mstatus_mie, mstatus_mpie,
        output trap_insert, stall_fetch, flush, pc_load, pc_next,
        output csr_trap_we, csr_mepc, csr_mcause, csr_mtval,
        output csr_status_we, mie_next, mpie_next, drain_timeout, trap_count
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap sequencer: accepts a trap/MRET request, waits for the data bus to drain
// (bounded by DRAIN_TIMEOUT), then issues one cycle of insert/redirect/flush
// followed by one cycle of CSR commit. All outputs are registered.
module trap_sequencer #(
    parameter int DRAIN_TIMEOUT = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic clk,
    input  logic rst_n,
    trap_sequencer_if.slave bus
);
    // Drain counter only needs to reach DRAIN_TIMEOUT-1.
    localparam int DCW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);
    localparam logic [31:0]    WORD_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_INSERT,
        S_COMMIT
    } state_t;

    state_t               state_q, state_d;

    // Captured trap descriptor and mstatus snapshot.
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          epc_q, epc_d;
    logic [31:0]          cause_q, cause_d;
    logic [31:0]          val_q, val_d;
    logic                 mret_q, mret_d;
    logic                 mie_q, mie_d;
    logic                 mpie_q, mpie_d;

    logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Registered outputs.
    logic                 insert_q, insert_d;
    logic                 stall_q, stall_d;
    logic [31:0]          pc_next_q, pc_next_d;
    logic                 trap_we_q, trap_we_d;
    logic [31:0]          mepc_q, mepc_d;
    logic [31:0]          mcause_q, mcause_d;
    logic [31:0]          mtval_q, mtval_d;
    logic                 status_we_q, status_we_d;
    logic                 mie_next_q, mie_next_d;
    logic                 mpie_next_q, mpie_next_d;
    logic                 timeout_q, timeout_d;

    // Descriptor used when entering INSERT: live inputs straight from IDLE,
    // captured copy when coming out of DRAIN.
    logic                 go_insert;
    logic [31:0]          ins_addr;
    logic                 ins_mret;

    // Next-state and next-output computation; pulse outputs default low.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        val_d       = val_q;
        mret_d      = mret_q;
        mie_d       = mie_q;
        mpie_d      = mpie_q;
        drain_cnt_d = drain_cnt_q;
        count_d     = count_q;
        stall_d     = stall_q;
        insert_d    = 1'b0;
        pc_next_d   = 32'h0;
        trap_we_d   = 1'b0;
        mepc_d      = 32'h0;
        mcause_d    = 32'h0;
        mtval_d     = 32'h0;
        status_we_d = 1'b0;
        mie_next_d  = 1'b0;
        mpie_next_d = 1'b0;
        timeout_d   = 1'b0;
        go_insert   = 1'b0;
        ins_addr    = addr_q;
        ins_mret    = mret_q;

        unique case (state_q)
            S_IDLE: begin
                stall_d = 1'b0;
                if (bus.trap_req) begin
                    addr_d      = bus.trap_addr;
                    epc_d       = bus.trap_epc;
                    cause_d     = bus.trap_cause;
                    val_d       = bus.trap_val;
                    mret_d      = bus.trap_is_mret;
                    mie_d       = bus.mstatus_mie;
                    mpie_d      = bus.mstatus_mpie;
                    drain_cnt_d = '0;
                    stall_d     = 1'b1;
                    ins_addr    = bus.trap_addr;
                    ins_mret    = bus.trap_is_mret;
                    if (bus.mem_busy) begin
                        state_d = S_DRAIN;
                    end else begin
                        go_insert = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.mem_busy) begin
                    go_insert = 1'b1;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    go_insert = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            S_INSERT: begin
                state_d     = S_COMMIT;
                status_we_d = 1'b1;
                if (mret_q) begin
                    mie_next_d  = mpie_q;
                    mpie_next_d = 1'b1;
                end else begin
                    trap_we_d   = 1'b1;
                    mepc_d      = epc_q & WORD_MASK;
                    mcause_d    = cause_q;
                    mtval_d     = val_q;
                    mie_next_d  = 1'b0;
                    mpie_next_d = mie_q;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                stall_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                stall_d = 1'b0;
            end
        endcase

        if (go_insert) begin
            state_d   = S_INSERT;
            insert_d  = 1'b1;
            pc_next_d = ins_addr & WORD_MASK;
            if (!ins_mret && (count_q != '1)) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    // State, capture and output registers; async reset aborts any sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0;
            epc_q       <= 32'h0;
            cause_q     <= 32'h0;
            val_q       <= 32'h0;
            mret_q      <= 1'b0;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            drain_cnt_q <= '0;
            count_q     <= '0;
            insert_q    <= 1'b0;
            stall_q     <= 1'b0;
            pc_next_q   <= 32'h0;
            trap_we_q   <= 1'b0;
            mepc_q      <= 32'h0;
            mcause_q    <= 32'h0;
            mtval_q     <= 32'h0;
            status_we_q <= 1'b0;
            mie_next_q  <= 1'b0;
            mpie_next_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            val_q       <= val_d;
            mret_q      <= mret_d;
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
            drain_cnt_q <= drain_cnt_d;
            count_q     <= count_d;
            insert_q    <= insert_d;
            stall_q     <= stall_d;
            pc_next_q   <= pc_next_d;
            trap_we_q   <= trap_we_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            status_we_q <= status_we_d;
            mie_next_q  <= mie_next_d;
            mpie_next_q <= mpie_next_d;
            timeout_q   <= timeout_d;
        end
    end

    // Insert, redirect and flush share one pulse register.
    assign bus.trap_insert   = insert_q;
    assign bus.pc_load       = insert_q;
    assign bus.flush         = insert_q;
    assign bus.stall_fetch   = stall_q;
    assign bus.pc_next       = pc_next_q;
    assign bus.csr_trap_we   = trap_we_q;
    assign bus.csr_mepc      = mepc_q;
    assign bus.csr_mcause    = mcause_q;
    assign bus.csr_mtval     = mtval_q;
    assign bus.csr_status_we = status_we_q;
    assign bus.mie_next      = mie_next_q;
    assign bus.mpie_next     = mpie_next_q;
    assign bus.drain_timeout = timeout_q;
    assign bus.trap_count    = count_q;
endmodule
